seg_scan_driver: RTL and testbench

Parametrised multiplexed seven-segment scan driver for the egg-timer display path. It time-multiplexes up to NUM_DIGITS glyphs onto shared active-low segment lines and active-low anodes, and supports a runtime-selectable scan length. It adds tear-free frame latching, PWM brightness, per-digit blink, per-digit decimal point and an extended glyph set. It sits between the timer/counter logic and the board pins, replacing fixed-count, fixed-brightness scanning.

---
 rtl/seg_scan_driver.sv | 166 ++++++++++++++++
 tb/tb_seg_scan_driver.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver: time-slices NUM_DIGITS glyphs onto shared
// active-low segment/anode pins with frame-latched data, PWM brightness and blink.
module seg_scan_driver #(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BRIGHT_W     = 4,
    parameter int unsigned BLINK_FRAMES = 64,
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [5*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [IDX_W:0]          active_digits,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              seg,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_start
);

    localparam int unsigned TCNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned LEN_W  = IDX_W + 1;

    logic [TCNT_W-1:0]       r_tcnt;
    logic [IDX_W-1:0]        r_idx;
    logic [LEN_W-1:0]        r_len;
    logic [FCNT_W-1:0]       r_fcnt;
    logic                    r_blink_phase;
    logic [5*NUM_DIGITS-1:0] r_glyph;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic [NUM_DIGITS-1:0]   r_blink;
    logic [BRIGHT_W-1:0]     r_bright;

    logic                    w_frame;
    logic                    w_slot_end;
    logic                    w_last;
    logic                    w_frame_end;
    logic [LEN_W-1:0]        w_len_clamped;
    logic [BRIGHT_W-1:0]     w_pcnt;
    logic [4:0]              w_glyph;
    logic                    w_dp_bit;
    logic                    w_blink_bit;
    logic                    w_lit;
    logic [NUM_DIGITS-1:0]   w_an_next;

    // Active-high a..g pattern for each 5-bit glyph code
    function automatic logic [6:0] font_lut(input logic [4:0] code);
        logic [6:0] s;
        case (code)
            5'd0:    s = 7'h3F;
            5'd1:    s = 7'h06;
            5'd2:    s = 7'h5B;
            5'd3:    s = 7'h4F;
            5'd4:    s = 7'h66;
            5'd5:    s = 7'h6D;
            5'd6:    s = 7'h7D;
            5'd7:    s = 7'h07;
            5'd8:    s = 7'h7F;
            5'd9:    s = 7'h6F;
            5'd10:   s = 7'h77;
            5'd11:   s = 7'h7C;
            5'd12:   s = 7'h39;
            5'd13:   s = 7'h5E;
            5'd14:   s = 7'h79;
            5'd15:   s = 7'h71;
            5'd17:   s = 7'h40;
            5'd18:   s = 7'h08;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    assign digit_idx   = r_idx;
    assign w_frame     = (r_idx == '0) && (r_tcnt == '0);
    assign w_slot_end  = (r_tcnt == TCNT_W'(SCAN_DIV - 1));
    assign w_last      = ({1'b0, r_idx} == (r_len - LEN_W'(1)));
    assign w_frame_end = w_slot_end && w_last;
    assign w_pcnt      = r_tcnt[BRIGHT_W-1:0];

    // Scan length is clamped into 1..NUM_DIGITS before it is latched
    always_comb begin
        w_len_clamped = active_digits;
        if (active_digits == '0) begin
            w_len_clamped = LEN_W'(1);
        end else if (active_digits > LEN_W'(NUM_DIGITS)) begin
            w_len_clamped = LEN_W'(NUM_DIGITS);
        end
    end

    // Per-slot shadow data selection; loop form keeps non-power-of-two counts in range
    always_comb begin
        w_glyph     = 5'd16;
        w_dp_bit    = 1'b0;
        w_blink_bit = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (IDX_W'(i) == r_idx) begin
                w_glyph     = r_glyph[5*i +: 5];
                w_dp_bit    = r_dp[i];
                w_blink_bit = r_blink[i];
            end
        end
    end

    // Dead cycle at tcnt==0, PWM window 1..brightness, blink suppression
    assign w_lit = (r_tcnt != '0) && (w_pcnt != '0) && (w_pcnt <= r_bright)
                   && !(r_blink_phase && w_blink_bit);

    always_comb begin
        w_an_next = '1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (w_lit && (IDX_W'(i) == r_idx)) begin
                w_an_next[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tcnt        <= '0;
            r_idx         <= '0;
            r_len         <= LEN_W'(1);
            r_fcnt        <= '0;
            r_blink_phase <= 1'b0;
            r_glyph       <= {NUM_DIGITS{5'd16}};
            r_dp          <= '0;
            r_blink       <= '0;
            r_bright      <= '0;
            an            <= '1;
            seg           <= 8'hFF;
            frame_start   <= 1'b0;
        end else begin
            if (w_slot_end) begin
                r_tcnt <= '0;
                r_idx  <= w_last ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_tcnt <= r_tcnt + TCNT_W'(1);
            end

            // Blink toggle lands on the frame that starts right after the wrap
            if (w_frame_end) begin
                if (r_fcnt == FCNT_W'(BLINK_FRAMES - 1)) begin
                    r_fcnt        <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_fcnt <= r_fcnt + FCNT_W'(1);
                end
            end

            if (w_frame) begin
                r_glyph  <= digits;
                r_dp     <= dp_mask;
                r_blink  <= blink_mask;
                r_bright <= brightness;
                r_len    <= w_len_clamped;
            end

            an          <= w_an_next;
            seg         <= {~w_dp_bit, ~font_lut(w_glyph)};
            frame_start <= w_frame;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomised and directed bench for seg_scan_driver against a frame-offset reference model.
module tb_seg_scan_driver;

    localparam int ND = 4;
    localparam int SD = 16;
    localparam int BW = 4;
    localparam int BF = 2;

    logic            clk;
    logic            reset;
    logic [5*ND-1:0] digits;
    logic [ND-1:0]   dp_mask;
    logic [ND-1:0]   blink_mask;
    logic [2:0]      active_digits;
    logic [BW-1:0]   brightness;
    logic [ND-1:0]   an;
    logic [7:0]      seg;
    logic [1:0]      digit_idx;
    logic            frame_start;

    seg_scan_driver #(
        .NUM_DIGITS  (ND),
        .SCAN_DIV    (SD),
        .BRIGHT_W    (BW),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .digits       (digits),
        .dp_mask      (dp_mask),
        .blink_mask   (blink_mask),
        .active_digits(active_digits),
        .brightness   (brightness),
        .an           (an),
        .seg          (seg),
        .digit_idx    (digit_idx),
        .frame_start  (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic string font_str(input int g);
        case (g)
            0: return "abcdef";   1: return "bc";      2: return "abdeg";
            3: return "abcdg";    4: return "bcfg";    5: return "acdfg";
            6: return "acdefg";   7: return "abc";     8: return "abcdefg";
            9: return "abcdfg";   10: return "abcefg"; 11: return "cdefg";
            12: return "adef";    13: return "bcdeg";  14: return "adefg";
            15: return "aefg";    17: return "g";      18: return "d";
            default: return "";
        endcase
    endfunction

    function automatic logic [6:0] glyph_segs(input int g);
        string s;
        logic [6:0] r;
        s = font_str(g);
        r = '0;
        for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b1;
        return r;
    endfunction

    // Reference model: position inside the frame, frame number since reset, latched inputs
    int         m_k, m_frame, m_n, m_br;
    int         m_gl[ND];
    logic [3:0] m_dp, m_bl;
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    logic       exp_fs;
    int         exp_idx;

    always @(posedge clk) begin
        int  slot, t, ph, p;
        bit  lit;
        if (reset) begin
            m_k = 0; m_frame = 0; m_n = 1; m_br = 0; m_dp = '0; m_bl = '0;
            for (int i = 0; i < ND; i++) m_gl[i] = 16;
            exp_an = 4'hF; exp_seg = 8'hFF; exp_fs = 1'b0;
        end else begin
            slot = m_k / SD;
            t    = m_k % SD;
            p    = t % (1 << BW);
            ph   = (m_frame / BF) % 2;
            lit  = (t != 0) && (p >= 1) && (p <= m_br) && !(ph == 1 && m_bl[slot]);
            exp_an = 4'hF;
            if (lit) exp_an[slot] = 1'b0;
            exp_seg = {~m_dp[slot], ~glyph_segs(m_gl[slot])};
            exp_fs  = (m_k == 0);
            if (m_k == 0) begin
                for (int i = 0; i < ND; i++) m_gl[i] = int'(digits[5*i +: 5]);
                m_dp = dp_mask;
                m_bl = blink_mask;
                m_br = int'(brightness);
                m_n  = (active_digits == 0) ? 1 : (int'(active_digits) > ND ? ND : int'(active_digits));
            end
            m_k++;
            if (m_k >= m_n * SD) begin
                m_k = 0;
                m_frame++;
            end
        end
        exp_idx = m_k / SD;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("an", 32'(an), 32'(exp_an));
            chk("seg", 32'(seg), 32'(exp_seg));
            chk("frame_start", 32'(frame_start), 32'(exp_fs));
            chk("digit_idx", 32'(digit_idx), 32'(exp_idx));
        end
    end

    // Counts lit cycles of anode b over one frame window (frame_start to next frame_start)
    task automatic frame_scan(input int b, output int lit, output int per);
        int w;
        lit = 0; per = 0; w = 0;
        while (!frame_start && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (!frame_start) begin
            chk("frame_start_timeout", 32'(0), 32'(1));
            return;
        end
        do begin
            if (!an[b]) lit++;
            per++;
            @(negedge clk);
        end while (!frame_start && per < 400);
    endtask

    task automatic scan_expect(input string tag, input int b, input int exp_lit, input int exp_per);
        int lit, per;
        frame_scan(b, lit, per);
        chk({tag, "_lit"}, 32'(lit), 32'(exp_lit));
        chk({tag, "_period"}, 32'(per), 32'(exp_per));
    endtask

    initial begin
        int w, gap;
        reset = 1'b1;
        digits = {5'd17, 5'd2, 5'd1, 5'd0};
        dp_mask = '0; blink_mask = '0;
        active_digits = 3'd4; brightness = 4'd15;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("first_frame_start", 32'(frame_start), 32'(1));

        scan_expect("full0", 0, 15, 64);
        scan_expect("full1", 1, 15, 64);
        brightness = 4'd4;
        scan_expect("br_old", 0, 15, 64);
        scan_expect("br4", 0, 4, 64);
        brightness = 4'd0;
        scan_expect("br0_old", 2, 4, 64);
        scan_expect("br0", 0, 0, 64);

        brightness = 4'd15;
        active_digits = 3'd2;
        scan_expect("n2_old", 0, 0, 64);
        scan_expect("n2", 1, 15, 32);
        active_digits = 3'd0;
        scan_expect("n0_old", 0, 15, 32);
        scan_expect("n0", 0, 15, 16);
        active_digits = 3'd7;
        scan_expect("n7_old", 0, 15, 16);
        scan_expect("n7", 3, 15, 64);

        // Blink and decimal point from a fresh reset
        @(negedge clk);
        reset = 1'b1;
        blink_mask = 4'b0010; dp_mask = 4'b0001; active_digits = 3'd4;
        @(negedge clk);
        reset = 1'b0;
        scan_expect("blink_f0", 1, 15, 64);
        scan_expect("blink_f1", 1, 15, 64);
        scan_expect("blink_f2", 1, 0, 64);
        scan_expect("blink_f3", 1, 0, 64);
        scan_expect("blink_f4", 1, 15, 64);
        scan_expect("steady_f5", 0, 15, 64);
        scan_expect("steady_f6", 0, 15, 64);

        // Reset in the middle of slot 2
        w = 0;
        while (digit_idx != 2'd2 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("idx2_reached", 32'(digit_idx), 32'(2));
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_an", 32'(an), 32'hF);
        chk("midreset_idx", 32'(digit_idx), 32'(0));
        chk("midreset_seg", 32'(seg), 32'hFF);
        reset = 1'b0;
        repeat (130) @(negedge clk);

        // Randomised inputs, changed at random intervals, with occasional resets
        gap = 0;
        for (int c = 0; c < 4000; c++) begin
            if (gap == 0) begin
                digits        = 20'($urandom);
                dp_mask       = 4'($urandom);
                blink_mask    = 4'($urandom);
                active_digits = 3'($urandom_range(0, 7));
                brightness    = 4'($urandom);
                gap = int'($urandom_range(1, 60));
            end else begin
                gap--;
            end
            reset = ($urandom_range(0, 599) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
